// File: rtl/aes_uart_pkg.sv
// Shared frame definitions for the UART AES command protocol. The initiator
// and the target-side command logic both import this package so the two ends
// agree on frame lengths and the initiator's state encoding.
package aes_uart_pkg;

   // Initiator FSM states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TX_STROBE,
      ST_TX_HOLD,
      ST_TX_WAIT,
      ST_TX_GAP,
      ST_RX,
      ST_FINISH
   } state_e;

   // Frame layout: 16-byte request; 18-byte response made of 2 pad bytes
   // followed by 16 ciphertext bytes, MSB first.
   localparam int REQ_BYTES      = 16;
   localparam int RESP_BYTES     = 18;
   localparam int RESP_PAD_BYTES = 2;

   // One counter serves both directions, so it must reach RESP_BYTES.
   localparam int BYTE_CNT_W = 5;
   typedef logic [BYTE_CNT_W-1:0] byte_cnt_t;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag. Counts down once per clock and
// saturates at 0; a load takes priority over counting.
// Ports:
//   clk, rst     clock and synchronous active-high reset (count -> 0)
//   load         load load_value this cycle
//   load_value   value to load
//   zero         high while the count is 0
module cycle_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;

   // NOTE: sequential state is written with non-blocking (<=) so every
   // register samples the values from before the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/aes_uart_initiator.sv
// Host-side initiator for the UART AES command protocol. Sends a 128-bit
// plaintext as 16 bytes through an external UART transmitter, then collects
// the 18-byte response (2 pad bytes + 16 ciphertext bytes) from an external
// receiver, reporting the ciphertext or a response timeout.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   start_i            request, sampled only while ready_o is high
//   plaintext_i        plaintext, byte [127:120] sent first
//   ready_o            high in IDLE only
//   done_o             one-cycle pulse, ciphertext_o valid
//   timeout_o          one-cycle pulse, response timed out
//   ciphertext_o       last good result, held until the next done_o
//   tx_start_o         byte strobe to the transmitter
//   tx_data_o          byte to send, stable between strobes
//   tx_busy_i          transmitter busy
//   rx_data_ready_i    one-cycle pulse per received byte
//   rx_data_i          received byte, valid with the pulse
module aes_uart_initiator
   import aes_uart_pkg::*;
#(
   parameter int GAP_CYCLES     = 0,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic [127:0] plaintext_i,
   output logic         ready_o,
   output logic         done_o,
   output logic         timeout_o,
   output logic [127:0] ciphertext_o,
   output logic         tx_start_o,
   output logic [7:0]   tx_data_o,
   input  logic         tx_busy_i,
   input  logic         rx_data_ready_i,
   input  logic [7:0]   rx_data_i
);

   // The timer is shared by the TX gap and the RX timeout, so it must hold
   // the larger of the two loads.
   localparam int TIMER_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
   // The gap state exits on the cycle the timer reads zero, so loading
   // GAP_CYCLES-1 yields exactly GAP_CYCLES cycles in TX_GAP.
   localparam int GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   state_e           state_q, state_d;
   state_e           next_byte_state;
   byte_cnt_t        byte_cnt_q;
   logic [127:0]     shift_q;
   logic [119:0]     result_q;   // first 15 ciphertext bytes; the 16th goes straight out
   logic             rx_last;
   logic             timer_load;
   logic [TIMER_W-1:0] timer_value;
   logic             timer_zero;

   cycle_timer #(
      .WIDTH(TIMER_W)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load      (timer_load),
      .load_value(timer_value),
      .zero      (timer_zero)
   );

   assign next_byte_state = (byte_cnt_q < byte_cnt_t'(REQ_BYTES)) ? ST_TX_STROBE : ST_RX;
   assign rx_last = rx_data_ready_i && (byte_cnt_q == byte_cnt_t'(RESP_BYTES - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default assignment first, so no path leaves state_d unassigned
      // and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:      if (start_i) state_d = ST_TX_STROBE;
         ST_TX_STROBE: state_d = ST_TX_HOLD;
         // Busy lags the strobe by a cycle, so HOLD never looks at it.
         ST_TX_HOLD:   state_d = ST_TX_WAIT;
         ST_TX_WAIT: begin
            if (!tx_busy_i) state_d = (GAP_CYCLES > 0) ? ST_TX_GAP : next_byte_state;
         end
         ST_TX_GAP:    if (timer_zero) state_d = next_byte_state;
         ST_RX: begin
            // A byte arriving on the expiry cycle wins over the timeout.
            if (rx_last) state_d = ST_FINISH;
            else if (timer_zero && !rx_data_ready_i) state_d = ST_IDLE;
         end
         ST_FINISH:    state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Outputs and timer control.
   always_comb begin
      ready_o     = (state_q == ST_IDLE);
      tx_start_o  = (state_q == ST_TX_STROBE);
      done_o      = (state_q == ST_FINISH);
      timeout_o   = (state_q == ST_RX) && timer_zero && !rx_data_ready_i;
      timer_load  = 1'b0;
      timer_value = '0;
      if (state_q == ST_TX_WAIT && state_d == ST_TX_GAP) begin
         timer_load  = 1'b1;
         timer_value = TIMER_W'(GAP_LOAD);
      end else if ((state_q != ST_RX && state_d == ST_RX) ||
                   (state_q == ST_RX && rx_data_ready_i)) begin
         timer_load  = 1'b1;
         timer_value = TIMER_W'(TIMEOUT_CYCLES);
      end
   end

   // Control registers and visible outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_q   <= '0;
         tx_data_o    <= '0;
         ciphertext_o <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  byte_cnt_q <= '0;
                  tx_data_o  <= plaintext_i[127:120];
               end
            end
            ST_TX_HOLD: byte_cnt_q <= byte_cnt_q + 1'b1;
            ST_TX_WAIT, ST_TX_GAP: begin
               // tx_data_o only changes on entry to TX_STROBE.
               if (state_d == ST_TX_STROBE) tx_data_o <= shift_q[127:120];
               if (state_d == ST_RX) byte_cnt_q <= '0;
            end
            ST_RX: begin
               if (rx_data_ready_i) begin
                  byte_cnt_q <= byte_cnt_q + 1'b1;
                  // Loaded on the edge into FINISH so the new value is
                  // visible in the same cycle as done_o.
                  if (rx_last) ciphertext_o <= {result_q, rx_data_i};
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the data shift registers carry no reset: each is fully loaded
   // before it is read, so a reset would only cost routing.
   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && start_i) begin
         shift_q <= plaintext_i;
      end else if (state_q == ST_TX_HOLD) begin
         shift_q <= {shift_q[119:0], 8'h00};
      end
      if (state_q == ST_RX && rx_data_ready_i &&
          byte_cnt_q >= byte_cnt_t'(RESP_PAD_BYTES)) begin
         result_q <= {result_q[111:0], rx_data_i};
      end
   end

endmodule
